// File: rtl/sram_arb_pkg.sv
// Shared types for the fetch/data SRAM port arbiter: FSM states, grant owner codes
// and the starvation-counter width helper.
package sram_arb_pkg;

  typedef enum logic {ARB, LOCK} arb_state_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D, OWN_L} owner_e;

  // Counter must be able to hold the value MAX_WAIT itself.
  function automatic int starve_cnt_w(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/sram_arb_starve_cnt.sv
// Saturating counter of consecutive denied fetch cycles; sat flags that fetch
// must be forced ahead of data on the next arbitration.
module sram_arb_starve_cnt #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [W-1:0] MAX_VAL = W'(MAX);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != MAX_VAL)) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign sat = (cnt_reg == MAX_VAL);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between fetch (read-only) and data ports,
// data first with a fetch starvation guard and a data-side lock for atomics.
// Optional write-only loader port when SRAM_ARB_LOADER_PORT_EN is defined.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_W-1:0]     i_req_addr,
  output logic                  i_rsp_valid,
  output logic [DATA_W-1:0]     i_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_W-1:0]     d_req_addr,
  input  logic [DATA_W/8-1:0]   d_req_wstrb,
  input  logic [DATA_W-1:0]     d_req_wdata,
  input  logic                  d_req_lock,
  output logic                  d_rsp_valid,
  output logic [DATA_W-1:0]     d_rsp_data,
`ifdef SRAM_ARB_LOADER_PORT_EN
  input  logic                  l_req_valid,
  output logic                  l_req_ready,
  input  logic [ADDR_W-1:0]     l_req_addr,
  input  logic [DATA_W-1:0]     l_req_wdata,
`endif
  output logic [DATA_W/8-1:0]   sram_w_en,
  output logic [ADDR_W-1:0]     sram_address,
  output logic [DATA_W-1:0]     sram_write_data,
  input  logic [DATA_W-1:0]     sram_read_data
);

  localparam int CNT_W = starve_cnt_w(MAX_WAIT);

  arb_state_e state_reg, state_next;
  owner_e     owner;
  logic       starve_sat;
  logic       i_rsp_valid_reg, d_rsp_valid_reg;

  sram_arb_starve_cnt #(.MAX(MAX_WAIT), .W(CNT_W)) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .inc (i_req_valid && !i_req_ready),
    .clr ((owner == OWN_I) || !i_req_valid),
    .sat (starve_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ARB;
    else     state_reg <= state_next;
  end

  // The lock is entered or released only by a data transfer.
  always_comb begin
    state_next = state_reg;
    if (owner == OWN_D) state_next = d_req_lock ? LOCK : ARB;
  end

  // Grant selection; nothing is granted while reset is asserted.
  always_comb begin
    owner = OWN_NONE;
    if (!rst) begin
      if (state_reg == LOCK) begin
        if (d_req_valid) owner = OWN_D;
      end
`ifdef SRAM_ARB_LOADER_PORT_EN
      else if (l_req_valid)              owner = OWN_L;
`endif
      else if (starve_sat && i_req_valid) owner = OWN_I;
      else if (d_req_valid)               owner = OWN_D;
      else if (i_req_valid)               owner = OWN_I;
    end
  end

  assign i_req_ready = (owner == OWN_I);
  assign d_req_ready = (owner == OWN_D);
`ifdef SRAM_ARB_LOADER_PORT_EN
  assign l_req_ready = (owner == OWN_L);
`endif

  always_comb begin
    sram_w_en       = '0;
    sram_address    = '0;
    sram_write_data = '0;
    case (owner)
      OWN_I: sram_address = i_req_addr;
      OWN_D: begin
        sram_w_en       = d_req_wstrb;
        sram_address    = d_req_addr;
        sram_write_data = d_req_wdata;
      end
`ifdef SRAM_ARB_LOADER_PORT_EN
      OWN_L: begin
        sram_w_en       = '1;
        sram_address    = l_req_addr;
        sram_write_data = l_req_wdata;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rsp_valid_reg <= 1'b0;
      d_rsp_valid_reg <= 1'b0;
    end else begin
      i_rsp_valid_reg <= (owner == OWN_I);
      d_rsp_valid_reg <= (owner == OWN_D) && (d_req_wstrb == '0);
    end
  end

  // Masking with rst drops a response whose read was granted just before reset.
  assign i_rsp_valid = i_rsp_valid_reg && !rst;
  assign d_rsp_valid = d_rsp_valid_reg && !rst;
  assign i_rsp_data  = i_rsp_valid ? sram_read_data : '0;
  assign d_rsp_data  = d_rsp_valid ? sram_read_data : '0;

endmodule
